// File: rtl/wptr_full_ctrl_pkg.sv
// Shared constants and pointer helpers for the asynchronous FIFO.
// Used by both the write-side (wptr_full_ctrl) and read-side controllers.
//   DEF_ADDR_WIDTH : default memory address width (depth = 2**DEF_ADDR_WIDTH)
//   PTR_W          : pointer width, one extra bit to tell full from empty
//   bin2gray/gray2bin : conversions at the default pointer width
package wptr_full_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int PTR_W          = DEF_ADDR_WIDTH + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b = '0;
    for (int i = 0; i < PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO bus between the producer and wptr_full_ctrl.
// Handshake: a word is accepted in a cycle exactly when wr_en=1 and full=0;
// mem_we reports that acceptance combinationally in the same cycle, and the
// data is written at the current wr_addr. wr_en while full is refused and
// sets the sticky overflow flag.
//   master : producer side (drives wr_en, sync_rptr, clr_overflow)
//   slave  : controller side (drives mem_we, wr_addr, wr_ptr, flags, level)
interface wptr_full_ctrl_if #(
  parameter int ADDR_WIDTH = wptr_full_ctrl_pkg::DEF_ADDR_WIDTH
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   sync_rptr;
  logic                  clr_overflow;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  modport master (
    output wr_en, sync_rptr, clr_overflow,
    input  mem_we, wr_addr, wr_ptr, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, sync_rptr, clr_overflow,
    output mem_we, wr_addr, wr_ptr, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter of parameterized width.
//   gray_i : Gray-coded input
//   bin_o  : binary equivalent (bit i = XOR of gray_i[W-1:i])
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end
endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO.
// Runs only in the write clock domain. Advances the binary/Gray write
// pointers on accepted writes, drives the memory strobe/address, and derives
// full, almost_full, fill level and sticky overflow from the synchronized
// Gray read pointer.
//   Src_clk : write-domain clock
//   rst     : asynchronous active-high reset
//   bus     : slave side of wptr_full_ctrl_if (see interface for handshake)
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 14
) (
  input  logic             Src_clk,
  input  logic             rst,
  wptr_full_ctrl_if.slave  bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  logic [PW-1:0]         wbin_q,  wbin_d;
  logic [PW-1:0]         wgray_q, wgray_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  full_q,  full_d;
  logic                  af_q,    af_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  ovf_q,   ovf_d;

  logic                  push;
  logic [PW-1:0]         rbin;
  logic [PW-1:0]         full_ptr;

  gray2bin #(.W(PW)) u_rptr_g2b (
    .gray_i (bus.sync_rptr),
    .bin_o  (rbin)
  );

  // Gating with rst keeps the strobe low while reset is held, even though
  // full is already cleared then.
  assign push = bus.wr_en & ~full_q & ~rst;

  // Full when the write pointer is one lap ahead of the read pointer: in
  // Gray code that means the top two bits differ and the rest match.
  assign full_ptr = {~bus.sync_rptr[PW-1:PW-2], bus.sync_rptr[PW-3:0]};

  always_comb begin
    wbin_d  = wbin_q + {{(PW-1){1'b0}}, push};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    waddr_d = wbin_d[ADDR_WIDTH-1:0];
    full_d  = (wgray_d == full_ptr);
    // Modular subtraction keeps the level right across pointer wrap.
    level_d = wbin_d - rbin;
    af_d    = (level_d >= AF_T);
    ovf_d   = ovf_q;
    if (bus.clr_overflow) ovf_d = 1'b0;
    if (bus.wr_en && full_q) ovf_d = 1'b1;  // set wins over clear
  end

  always_ff @(posedge Src_clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      waddr_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      waddr_q <= waddr_d;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.mem_we      = push;
  assign bus.wr_addr     = waddr_q;
  assign bus.wr_ptr      = wgray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.wr_level    = level_q;
  assign bus.overflow    = ovf_q;

endmodule
